nco_freq_meter: RTL
===================

// Module: nco_freq_meter
// PURPOSE
//  Measures the frequency of a 14-bit signed sinusoid. Sources are the NCO sin output looped
//  back, or an ADC capture. The result is returned as a 28-bit frequency control word on the
//  same scale as the NCO: word = f_in * 2^28 / f_clk, so 28'd67108864 = clk/4.
//  The word can be fed straight back into an NCO. The measurement averages over a programmable
//  number of signal periods and uses a multi-cycle restoring divider.
// PARAMETERS
//  DATA_WIDTH  28   width of the frequency word produced
//  SAMPLE_W    14   width of sample_in, two's complement
//  HYST        64   zero-crossing hysteresis, in LSBs (positive)
//  CNT_W       32   width of the clock-period counter; also sets the timeout
// PORTS
//  clk           in   1           clock; sample_in is valid on every edge
//  rst_n         in   1           reset: asynchronous, active-low
//  sample_in     in   SAMPLE_W    signed sample stream
//  gate_periods  in   8           periods to average; 0 is treated as 1; latched on start
//  start         in   1           one-cycle request; ignored while busy=1
//  busy          out  1           measurement in progress
//  fre_word      out  DATA_WIDTH  last measured frequency word; held until the next success
//  fre_valid     out  1           one-cycle pulse when fre_word updates
//  timeout       out  1           one-cycle pulse when a measurement aborts
// BEHAVIOUR
//  Reset values
//   - busy=0, fre_word=0, fre_valid=0, timeout=0, FSM=IDLE, all counters 0, below=0.
//   - Reset mid-operation aborts immediately. No fre_valid or timeout pulse is issued.
//  Crossing detector
//   - smp is sample_in registered on every edge.
//   - below is set when smp <= -HYST. below is cleared when a crossing fires.
//   - A crossing fires for one cycle when below=1 and smp >= +HYST.
//   - Samples inside (-HYST, +HYST) change nothing.
//   - The detector runs continuously in every state.
//  FSM states
//   - IDLE
//       - On start: latch N = max(gate_periods, 1), clear cyc and ncnt, busy<=1, go to ARM.
//   - ARM
//       - Wait for a crossing.
//       - On the first crossing: cyc<=0, go to COUNT.
//   - COUNT
//       - cyc increments on every cycle.
//       - Each crossing does ncnt++.
//       - When the crossing brings ncnt to N: capture D = cyc+1 and go to DIVIDE.
//       - D is the number of clk periods between the first and the Nth following crossing.
//   - DIVIDE
//       - Restoring division of (N << DATA_WIDTH), 36 bits, by D.
//       - One quotient bit per cycle, exactly 36 cycles.
//   - DONE
//       - If the quotient > 2^DATA_WIDTH-1, fre_word <= all-ones (saturate); otherwise fre_word <= quotient.
//       - fre_valid=1 for this one cycle, busy<=0, go to IDLE.
//  Timing and limits
//   - Latency: fre_valid is high exactly 38 cycles after the cycle where the final crossing pulse is high.
//   - The quotient is truncated, not rounded. D is never 0.
//   - Timeout: in ARM or COUNT, when the counter (ARM wait counter or cyc) reaches 2^CNT_W-1:
//       - pulse timeout, busy<=0, go to IDLE, fre_word unchanged.
//   - start asserted while busy=1 is ignored and not queued.
//   - start in DONE cycle: ignored.
//   - A crossing and a timeout on the same cycle: the crossing wins.
// TESTING
//  1 NCO loopback, clk/4
//     - Stimulus: fre_chtr=28'd67108864, gate_periods=4, start.
//     - Response: D=16, fre_word=28'd67108864, one fre_valid pulse.
//  2 NCO loopback, clk/16
//     - Stimulus: fre_chtr=28'd16777216, gate_periods=0 (treated as 1).
//     - Response: fre_word=28'd16777216. fre_valid lands 38 cycles after the closing crossing.
//  3 Dead input
//     - Stimulus: CNT_W=12, sample_in held at 0, start.
//     - Response: timeout pulse after ~4095 cycles, busy falls, fre_word keeps its old value.
//  4 Noise and hysteresis
//     - Stimulus: a clk/8 square wave of ±2000 with ±40 noise around each edge, HYST=64, gate_periods=8.
//     - Response: exactly one crossing per period, fre_word=28'd33554432.
//  5 Protocol
//     - Stimulus: start pulsed again during COUNT.
//     - Response: ignored; a single fre_valid pulse; the result is unchanged.
//  6 Reset mid-DIVIDE
//     - Stimulus: rst_n low for 1 cycle.
//     - Response: all outputs 0, no pulses; a new start then measures correctly.

Source files
------------

// File: rtl/nco_freq_meter.sv
// nco_freq_meter
//   Measures the frequency of a signed sample stream (NCO loopback or ADC
//   capture) and reports it as a frequency control word on the NCO scale:
//   word = f_in * 2^DATA_WIDTH / f_clk. The measurement averages over a
//   programmable number of signal periods. The quotient N*2^DATA_WIDTH / D
//   comes from a multi-cycle restoring divider, where D is the measured
//   span in clock periods.
//
// Ports
//   clk           in   clock; sample_in is sampled on every rising edge
//   rst_n         in   asynchronous active-low reset
//   sample_in     in   [SAMPLE_W-1:0] two's-complement sample stream
//   gate_periods  in   [7:0] periods to average (0 behaves as 1), latched on start
//   start         in   one-cycle request, ignored while busy
//   busy          out  measurement in progress
//   fre_word      out  [DATA_WIDTH-1:0] last successful measurement, held
//   fre_valid     out  one-cycle pulse when fre_word updates
//   timeout       out  one-cycle pulse when a measurement aborts
module nco_freq_meter #(
  parameter int DATA_WIDTH = 28,
  parameter int SAMPLE_W   = 14,
  parameter int HYST       = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic [7:0]            gate_periods,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] fre_word,
  output logic                  fre_valid,
  output logic                  timeout
);

  // The dividend N << DATA_WIDTH needs 8 extra bits for N up to 255.
  localparam int DIV_W     = DATA_WIDTH + 8;
  localparam int DIV_CNT_W = $clog2(DIV_W);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_W - 1);
  localparam logic [CNT_W-1:0]     CYC_MAX  = '1;
  localparam logic signed [SAMPLE_W-1:0] HYST_P = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_N = SAMPLE_W'(-HYST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DIVIDE,
    S_DONE
  } state_t;

  // Quotients that do not fit the output word clamp to all-ones.
  function automatic logic [DATA_WIDTH-1:0] sat_word(input logic [DIV_W-1:0] q);
    if (|q[DIV_W-1:DATA_WIDTH]) begin
      return '1;
    end
    return q[DATA_WIDTH-1:0];
  endfunction

  state_t                       state_q, state_d;
  logic signed [SAMPLE_W-1:0]   smp_q, smp_d;
  logic                         below_q, below_d;
  logic [7:0]                   n_q, n_d;
  logic [7:0]                   ncnt_q, ncnt_d;
  logic [CNT_W-1:0]             cyc_q, cyc_d;
  logic [DIV_CNT_W-1:0]         div_cnt_q, div_cnt_d;
  logic                         busy_q, busy_d;
  logic [DATA_WIDTH-1:0]        fre_word_q, fre_word_d;
  logic                         fre_valid_q, fre_valid_d;
  logic                         timeout_q, timeout_d;

  // Divider datapath: divisor, partial remainder, dividend/quotient shifter.
  // D can reach 2^CNT_W when a crossing lands on the last count, so it
  // carries one extra bit.
  logic [CNT_W:0]               d_q, d_d;
  logic [CNT_W:0]               rem_q, rem_d;
  logic [DIV_W-1:0]             quo_q, quo_d;

  logic                         crossing;
  logic [CNT_W+1:0]             rem_sh;
  logic [CNT_W:0]               rem_sub;

  always_comb begin
    state_d     = state_q;
    smp_d       = $signed(sample_in);
    below_d     = below_q;
    n_d         = n_q;
    ncnt_d      = ncnt_q;
    cyc_d       = cyc_q;
    div_cnt_d   = div_cnt_q;
    busy_d      = busy_q;
    fre_word_d  = fre_word_q;
    fre_valid_d = 1'b0;
    timeout_d   = 1'b0;
    d_d         = d_q;
    rem_d       = rem_q;
    quo_d       = quo_q;

    // Hysteresis detector: arm on a clearly negative sample, fire on the
    // first clearly positive one afterwards. Runs in every state.
    crossing = below_q && (smp_q >= HYST_P);
    if (crossing) begin
      below_d = 1'b0;
    end else if (smp_q <= HYST_N) begin
      below_d = 1'b1;
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits. The subtraction result is below
    // D, so dropping the top bit is exact.
    rem_sh  = {rem_q, quo_q[DIV_W-1]};
    rem_sub = rem_sh[CNT_W:0] - d_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (gate_periods == 8'd0) ? 8'd1 : gate_periods;
          cyc_d   = '0;
          ncnt_d  = '0;
          busy_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (crossing) begin
          cyc_d   = '0;
          state_d = S_COUNT;
        end else if (cyc_q == CYC_MAX) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (crossing && (ncnt_q + 8'd1 == n_q)) begin
          d_d       = {1'b0, cyc_q} + (CNT_W + 1)'(1);
          quo_d     = {n_q, {DATA_WIDTH{1'b0}}};
          rem_d     = '0;
          div_cnt_d = '0;
          state_d   = S_DIVIDE;
        end else if (crossing) begin
          // A crossing beats a timeout; hold the counter at its ceiling so
          // the next quiet cycle still aborts instead of wrapping.
          ncnt_d = ncnt_q + 8'd1;
          cyc_d  = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
        end else if (cyc_q == CYC_MAX) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DIVIDE: begin
        if (rem_sh >= {1'b0, d_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[CNT_W:0];
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        if (div_cnt_q == DIV_LAST) begin
          state_d = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        fre_word_d  = sat_word(quo_q);
        fre_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      smp_q       <= '0;
      below_q     <= 1'b0;
      n_q         <= '0;
      ncnt_q      <= '0;
      cyc_q       <= '0;
      div_cnt_q   <= '0;
      busy_q      <= 1'b0;
      fre_word_q  <= '0;
      fre_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      below_q     <= below_d;
      n_q         <= n_d;
      ncnt_q      <= ncnt_d;
      cyc_q       <= cyc_d;
      div_cnt_q   <= div_cnt_d;
      busy_q      <= busy_d;
      fre_word_q  <= fre_word_d;
      fre_valid_q <= fre_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Divider datapath registers; always loaded before use
  always_ff @(posedge clk) begin
    d_q   <= d_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
  end

  assign busy      = busy_q;
  assign fre_word  = fre_word_q;
  assign fre_valid = fre_valid_q;
  assign timeout   = timeout_q;

endmodule
